sub_div_seq: RTL

- Multi-cycle unsigned divider controller that time-shares the ALU's 32-bit borrow-chain subtractor to perform restoring division, one trial subtraction per clock.
- The block owns no subtract logic. It drives the subtractor's operand inputs and consumes its difference and borrow-out.
- It sits beside the ALU and serves DIV/REM requests through a valid/ready handshake.

---
 rtl/sub_div_seq_if.sv | 27 ++
 rtl/sub_div_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sub_div_seq_if.sv
// Request/response bundle for the sequential divider: the master issues
// requests and takes results, the slave (the divider) serves them.
interface sub_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both 1. Once raised, out_valid and its payload stay stable until taken.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/sub_div_seq.sv
// Restoring unsigned divider that borrows an external borrow-chain subtractor
// and performs one trial subtraction per clock.
module sub_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  sub_div_seq_if.slave     bus,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_borrow,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_zero_reg;

  logic [WIDTH:0]   s;
  logic             take;
  logic [WIDTH-1:0] r_new;
  logic [WIDTH-1:0] q_new;
  logic             last_step;

  // Shifted partial remainder; a set top bit means it already exceeds any D.
  assign s         = {r_reg, q_reg[WIDTH-1]};
  assign take      = s[WIDTH] | ~sub_borrow;
  assign r_new     = take ? sub_diff : s[WIDTH-1:0];
  assign q_new     = {q_reg[WIDTH-2:0], take};
  assign last_step = (count == CNT_W'(WIDTH - 1));

  // Operands are forced to zero outside ITER so the shared subtractor sees
  // nothing from this block while the ALU owns it.
  assign sub_a = (state == ITER) ? s[WIDTH-1:0] : '0;
  assign sub_b = (state == ITER) ? d_reg : '0;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.div_zero  = div_zero_reg;
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = (bus.divisor == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      count         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor == '0) begin
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend;
              div_zero_reg  <= 1'b1;
            end else begin
              r_reg        <= '0;
              q_reg        <= bus.dividend;
              d_reg        <= bus.divisor;
              count        <= '0;
              div_zero_reg <= 1'b0;
            end
          end
        end
        ITER: begin
          r_reg <= r_new;
          q_reg <= q_new;
          count <= count + 1'b1;
          if (last_step) begin
            quotient_reg  <= q_new;
            remainder_reg <= r_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
